// File: rtl/wb_spram_pkg.sv
// ---------------------------------------------------------------------------
// wb_spram_pkg
// Shared definitions for the Wishbone single-port RAM slice:
//   LAT_DIRECT / LAT_REG  - read/ack latency in cycles without / with the
//                           extra output register stage
//   sel_width()           - number of byte lanes for a given word width
//   stage_t               - one slot of the completion pipeline
// ---------------------------------------------------------------------------
package wb_spram_pkg;

  localparam int LAT_DIRECT = 1;
  localparam int LAT_REG    = 2;

  // One byte-lane select bit per 8 data bits.
  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  // Completion pending in a pipeline slot: normal ack or error ack.
  typedef struct packed {
    logic ack;
    logic err;
  } stage_t;

endpackage

// File: rtl/spram_be.sv
// ---------------------------------------------------------------------------
// spram_be
// Single-port RAM with per-byte write enables and synchronous read.
// The storage has no reset; contents survive any system reset.
// Ports:
//   clock  - write and read-register clock
//   en     - access enable for this cycle
//   we     - 1 = write, 0 = read
//   sel    - byte-lane write enables (bit n covers data bits 8n+7..8n)
//   addr   - word address (caller guarantees addr < WORDS when en = 1)
//   wdata  - write data
//   rdata  - registered read data; updates only on enabled reads
// ---------------------------------------------------------------------------
module spram_be #(
  parameter int WORDS      = 'h2000,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

  // Writes touch only the selected lanes; reads load the full word into
  // rdata, which then holds until the next enabled read.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        for (int n = 0; n < SEL_WIDTH; n++) begin
          if (sel[n]) begin
            mem[addr][8*n +: 8] <= wdata[8*n +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wb_spram.sv
// ---------------------------------------------------------------------------
// wb_spram
// Wishbone B4 pipelined slave wrapping a byte-enabled single-port RAM.
// Never stalls; every accepted request completes after 1 cycle
// (OUT_REG = 0) or 2 cycles (OUT_REG = 1), in issue order.
// Optional feature macro: WB_SPRAM_ERR_EN - out-of-range addresses
// complete with wb_err_o instead of wb_ack_o and do not access memory.
// Ports:
//   clock, reset   - clock and asynchronous active-high reset
//   wb_cyc_i       - bus cycle active; low cancels all pending completions
//   wb_stb_i       - request strobe
//   wb_we_i        - 1 = write, 0 = read
//   wb_adr_i       - word address
//   wb_sel_i       - byte-lane enables for writes
//   wb_dat_i       - write data
//   wb_dat_o       - read data, valid with wb_ack_o, otherwise holds
//   wb_ack_o       - one-cycle completion pulse
//   wb_stall_o     - always 0
//   wb_err_o       - error completion (0 unless WB_SPRAM_ERR_EN)
// ---------------------------------------------------------------------------
module wb_spram
  import wb_spram_pkg::*;
#(
  parameter  int SIZE       = 'h2000,
  parameter  int DATA_WIDTH = 16,
  parameter  int OUT_REG    = 0,
  localparam int ADDR_WIDTH = $clog2(SIZE),
  localparam int SEL_WIDTH  = sel_width(DATA_WIDTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic                  wb_err_o
);

  localparam int                LATENCY  = (OUT_REG != 0) ? LAT_REG : LAT_DIRECT;
  localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH + 1)'(SIZE);

  logic                  accept;
  logic                  in_range;
  logic                  bad_addr;
  logic                  mem_en;
  logic                  mem_rd;
  logic [DATA_WIDTH-1:0] ram_q;
  stage_t                s1;
  stage_t                s_out;

  assign accept   = wb_cyc_i & wb_stb_i;
  assign in_range = ({1'b0, wb_adr_i} < SIZE_EXT);

`ifdef WB_SPRAM_ERR_EN
  assign bad_addr = ~in_range;
`else
  assign bad_addr = 1'b0;
`endif

  // Out-of-range addresses never reach the array, whether or not they are
  // reported as errors. Requests during reset must not write memory.
  assign mem_en = accept & in_range & ~reset;
  assign mem_rd = mem_en & ~wb_we_i;

  spram_be #(
    .WORDS      (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_ram (
    .clock (clock),
    .en    (mem_en),
    .we    (wb_we_i),
    .sel   (wb_sel_i),
    .addr  (wb_adr_i),
    .wdata (wb_dat_i),
    .rdata (ram_q)
  );

  // First completion slot, loaded from the request accepted at this edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.ack <= accept & ~bad_addr;
      s1.err <= accept & bad_addr;
    end
  end

  generate
    if (LATENCY == LAT_REG) begin : g_out_reg
      stage_t                s2;
      logic                  rd1;
      logic [DATA_WIDTH-1:0] dat_q;

      // Second slot plus output data register. A low wb_cyc_i kills the
      // completion moving through, and its data is not captured either.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rd1   <= 1'b0;
          s2    <= '0;
          dat_q <= '0;
        end else begin
          rd1 <= mem_rd;
          s2  <= wb_cyc_i ? s1 : '0;
          if (wb_cyc_i && rd1) begin
            dat_q <= ram_q;
          end
        end
      end

      assign s_out    = s2;
      assign wb_dat_o = dat_q;
    end else begin : g_direct
      logic have_data;

      // The RAM register itself cannot be reset, so its output is masked
      // to zero until the first read after reset has loaded it.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          have_data <= 1'b0;
        end else if (mem_rd) begin
          have_data <= 1'b1;
        end
      end

      assign s_out    = s1;
      assign wb_dat_o = have_data ? ram_q : '0;
    end
  endgenerate

  // Completions only ever appear inside an active bus cycle.
  assign wb_ack_o   = s_out.ack & wb_cyc_i;
  assign wb_err_o   = s_out.err & wb_cyc_i;
  assign wb_stall_o = 1'b0;

endmodule

// File: doc/wb_spram.md
WB_SPRAM -- requirements
Module: wb_spram

Interface
REQ-001 Parameter SIZE, default 'h2000: number of memory words; need not be a power of two.
REQ-002 Parameter DATA_WIDTH, default 16: word width; SHALL be a multiple of 8.
REQ-003 Parameter OUT_REG, default 0: 0 = 1-cycle read latency; 1 = extra output register stage, 2-cycle latency.
REQ-004 Derived ADDR_WIDTH = $clog2(SIZE); SEL_WIDTH = DATA_WIDTH/8.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wb_cyc_i  in  1  bus cycle active.
REQ-008 wb_stb_i  in  1  request strobe (Wishbone B4 pipelined).
REQ-009 wb_we_i  in  1  1 = write, 0 = read.
REQ-010 wb_adr_i  in  ADDR_WIDTH  word address.
REQ-011 wb_sel_i  in  SEL_WIDTH  byte-lane enables; bit n covers data bits 8n+7..8n.
REQ-012 wb_dat_i  in  DATA_WIDTH  write data.
REQ-013 wb_dat_o  out  DATA_WIDTH  read data, valid only while wb_ack_o = 1.
REQ-014 wb_ack_o  out  1  one-cycle completion pulse per accepted request.
REQ-015 wb_stall_o  out  1  constant 0; a request is accepted every cycle.
REQ-016 wb_err_o  out  1  error completion (present only with WB_SPRAM_ERR_EN, else tied 0).

Function
REQ-017 Request accepted in cycle t iff wb_cyc_i & wb_stb_i at the rising edge of t.
REQ-018 Accepted write: lanes with wb_sel_i[n] = 1 updated at edge t; lanes with wb_sel_i[n] = 0 unchanged; wb_sel_i = 0 writes nothing but still acks.
REQ-019 Accepted read: memory word sampled at edge t; wb_sel_i ignored, full word returned.
REQ-020 OUT_REG = 0: wb_ack_o = 1 in cycle t+1; OUT_REG = 1: wb_ack_o = 1 in cycle t+2.
REQ-021 Back-to-back requests SHALL produce back-to-back acks in issue order, one per request, never merged or dropped.
REQ-022 Read-after-write to the same address in consecutive cycles SHALL return the newly written data (write at t completes before read sampled at t+1).
REQ-023 Same-cycle read/write not possible (single port); a write's wb_dat_o value is don't-care.
REQ-024 wb_cyc_i = 0 in any cycle SHALL cancel every in-flight ack/err in that cycle; no completion is issued outside wb_cyc_i = 1.
REQ-025 Writes already performed before cancellation remain in memory.
REQ-026 wb_dat_o holds its last value when wb_ack_o = 0 (no forced zero).

Reset
REQ-027 On reset assertion, asynchronously: wb_ack_o = 0, wb_err_o = 0, all pipeline valid bits = 0, wb_dat_o = 0.
REQ-028 Memory contents SHALL NOT be reset or altered by reset.
REQ-029 Requests presented while reset = 1 are ignored; no write, no ack.
REQ-030 Reset mid-transfer discards all outstanding completions; first request after deassertion behaves as REQ-020.

Configuration
REQ-031 Macro WB_SPRAM_ERR_EN defined: request with wb_adr_i >= SIZE performs no memory access and completes with wb_err_o = 1, wb_ack_o = 0, same latency as REQ-020.
REQ-032 Macro WB_SPRAM_ERR_EN undefined: wb_err_o tied 0; out-of-range address is acked, write discarded, read data undefined.

Structure
REQ-033 Shared package wb_spram_pkg holds latency constants (LAT_DIRECT = 1, LAT_REG = 2) and the SEL_WIDTH derivation function.
REQ-034 Storage in sub-module spram_be (single-port, byte-enable, synchronous read, no reset); wb_spram holds handshake, ack/err pipeline, optional output register.

Verification
REQ-035 Write 'h1234 to 'h0010 with sel=2'b11, read 'h0010 -> ack at t+1 (OUT_REG=0) with dat_o='h1234.
REQ-036 Write 'hABCD sel=2'b01 over 'h1234 at 'h0020 -> read returns 'h12CD; sel=2'b00 write leaves it 'h12CD.
REQ-037 Four back-to-back reads 'h0..'h3 with OUT_REG=1 -> four consecutive acks starting t+2, data in address order.
REQ-038 Read issued, wb_cyc_i dropped next cycle -> no ack; reset pulsed mid-burst -> acks cleared, memory contents intact.
REQ-039 SIZE='h1800, WB_SPRAM_ERR_EN defined, write to 'h1800 -> wb_err_o at t+1, wb_ack_o 0, 'h0000 unchanged.
REQ-040 Write 'h5555 at t, read same address at t+1 -> ack at t+2 with 'h5555.
